// File: rtl/mko_pkg.sv
// -----------------------------------------------------------------------------
// mko_pkg
// Shared definitions for the MKO device responder: FSM state encoding,
// CSR bit positions, the address bit that selects the CSR, the default
// number of wait states, and small helper functions for CSR packing and
// strap parity checking.
// -----------------------------------------------------------------------------
package mko_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_HOLD = 2'd3
   } mko_state_e;

   localparam int MKO_CSR_INT_BIT     = 15;
   localparam int MKO_CSR_PAR_BIT     = 14;
   localparam int MKO_CSR_RT_MSB      = 4;
   localparam int MKO_CSR_RT_LSB      = 0;
   localparam int MKO_CSR_SEL_BIT     = 12;
   localparam int MKO_DEF_WAIT_CYCLES = 2;

   // Assemble the CSR read value from its status fields.
   function automatic logic [15:0] mko_csr_pack(input logic       int_pend,
                                                input logic       par_err,
                                                input logic [4:0] rt_adr);
      logic [15:0] v;
      v = 16'h0000;
      v[MKO_CSR_INT_BIT] = int_pend;
      v[MKO_CSR_PAR_BIT] = par_err;
      v[MKO_CSR_RT_MSB:MKO_CSR_RT_LSB] = rt_adr;
      return v;
   endfunction

   // Odd/even mismatch between the RT address straps and their parity strap.
   function automatic logic mko_strap_par_err(input logic [4:0] rdat,
                                              input logic       rdatp);
      return ((^rdat) != rdatp);
   endfunction

endpackage

// File: rtl/mko_dev_mem.sv
// -----------------------------------------------------------------------------
// mko_dev_mem
// Single-port word memory, synchronous write and registered read. Contents
// have no reset so they survive both block reset and host device reset.
// Ports:
//   i_clk    clock
//   i_we     write enable (one cycle)
//   i_re     read enable; o_rdata updates one edge later and then holds
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module mko_dev_mem #(
   parameter int AW = 6
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [15:0]   i_wdata,
   output logic [15:0]   o_rdata
);

   logic [15:0] r_mem [0:(1<<AW)-1];
   logic [15:0] r_rdata;

   // Storage array write port.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read register; holds its value between reads so the bus stays stable.
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mko_dev_responder.sv
// -----------------------------------------------------------------------------
// mko_dev_responder
// Remote-terminal side responder for the MKO host bus. A strobed, selected
// access is latched, held for WAIT_CYCLES wait states, then acknowledged with
// READYD_N low; reads drive the data bus until the host lifts the strobe.
// Address bit 12 selects the CSR, otherwise a word of the internal memory.
//
// Parameters:
//   WAIT_CYCLES  wait states before READYD_N falls (0..15)
//   MEM_AW       internal memory address width (2**MEM_AW x 16)
// Ports:
//   i_clk_16          clock, all logic on the rising edge
//   i_reset           synchronous active-high reset
//   i_mko_res_n       host device reset, active low (captures RT straps)
//   i_mko_strbd_n     data strobe, active low
//   i_mko_select_n    device select, active low
//   i_mko_rdwr_n      1 = host read, 0 = host write
//   i_adr_mko         host address
//   io_data_mko       bidirectional data bus (driven only while acknowledging a read)
//   i_mko_rdat        RT address straps
//   i_mko_rdatp       RT address strap parity
//   o_mko_readyd_n    transfer-ready handshake, active low, registered
//   o_mko_int         interrupt request (pending flag)
//   i_evt             internal event pulse that raises the interrupt
// Configuration:
//   MKO_DEV_PARITY_EN  when defined, par_err records a strap parity mismatch
//                      seen while i_mko_res_n is low; otherwise it is 0.
// -----------------------------------------------------------------------------
module mko_dev_responder
   import mko_pkg::*;
#(
   parameter int WAIT_CYCLES = MKO_DEF_WAIT_CYCLES,
   parameter int MEM_AW      = 6
) (
   input  logic        i_clk_16,
   input  logic        i_reset,
   input  logic        i_mko_res_n,
   input  logic        i_mko_strbd_n,
   input  logic        i_mko_select_n,
   input  logic        i_mko_rdwr_n,
   input  logic [15:0] i_adr_mko,
   inout  wire  [15:0] io_data_mko,
   input  logic [4:0]  i_mko_rdat,
   input  logic        i_mko_rdatp,
   output logic        o_mko_readyd_n,
   output logic        o_mko_int,
   input  logic        i_evt
);

   mko_state_e         r_state;
   mko_state_e         w_state_nxt;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic               w_latch;
   logic               w_commit;

   logic [MEM_AW-1:0]  r_mem_adr;
   logic               r_sel_csr;
   logic               r_rdwr_n;
   logic [15:0]        r_wdata;

   logic               r_readyd_n;
   logic               r_drive;
   logic               r_rd_csr;
   logic [15:0]        r_csr_rdata;

   logic               r_int_pend;
   logic               r_par_err;
   logic [4:0]         r_rt_adr;

   logic               w_mem_we;
   logic               w_mem_re;
   logic               w_csr_clr;
   logic [15:0]        w_mem_rdata;
   logic [15:0]        w_rdata;
   logic               w_unused_adr;

   // Upper address bits outside the decode are intentionally ignored.
   assign w_unused_adr = ^i_adr_mko;

   // Next-state logic. The commit happens on the WAIT->ACK edge so a write
   // lands exactly once and read data is registered as READYD_N falls.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_commit    = 1'b0;
      if (i_reset || !i_mko_res_n) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!i_mko_strbd_n && !i_mko_select_n) begin
                  w_latch     = 1'b1;
                  w_cnt_nxt   = 4'(WAIT_CYCLES);
                  w_state_nxt = ST_WAIT;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_WAIT: begin
               // Abort takes priority over completion: no side effects.
               if (i_mko_strbd_n || i_mko_select_n) begin
                  w_state_nxt = ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  w_commit    = 1'b1;
                  w_state_nxt = ST_ACK;
               end else begin
                  w_cnt_nxt   = r_cnt - 4'd1;
               end
            end
            ST_ACK: begin
               w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
               if (i_mko_strbd_n) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign w_mem_we  = w_commit && !r_rdwr_n && !r_sel_csr;
   assign w_mem_re  = w_commit &&  r_rdwr_n && !r_sel_csr;
   assign w_csr_clr = w_commit && !r_rdwr_n &&  r_sel_csr && r_wdata[MKO_CSR_INT_BIT];

   // FSM state and wait-state counter.
   always_ff @(posedge i_clk_16) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Access capture at the strobe-sampling edge.
   always_ff @(posedge i_clk_16) begin
      if (i_reset) begin
         r_mem_adr <= '0;
         r_sel_csr <= 1'b0;
         r_rdwr_n  <= 1'b1;
         r_wdata   <= 16'h0000;
      end else if (w_latch) begin
         r_mem_adr <= i_adr_mko[MEM_AW-1:0];
         r_sel_csr <= i_adr_mko[MKO_CSR_SEL_BIT];
         r_rdwr_n  <= i_mko_rdwr_n;
         r_wdata   <= io_data_mko;
      end
   end

   // Handshake and bus-drive registers: asserted at commit, released when
   // the host lifts the strobe in HOLD, or forced off by either reset.
   always_ff @(posedge i_clk_16) begin
      if (i_reset) begin
         r_readyd_n <= 1'b1;
         r_drive    <= 1'b0;
      end else if (!i_mko_res_n) begin
         r_readyd_n <= 1'b1;
         r_drive    <= 1'b0;
      end else if (w_commit) begin
         r_readyd_n <= 1'b0;
         r_drive    <= r_rdwr_n;
      end else if ((r_state == ST_HOLD) && i_mko_strbd_n) begin
         r_readyd_n <= 1'b1;
         r_drive    <= 1'b0;
      end
   end

   // CSR read snapshot and read-source select, taken at a read commit.
   always_ff @(posedge i_clk_16) begin
      if (i_reset) begin
         r_rd_csr    <= 1'b0;
         r_csr_rdata <= 16'h0000;
      end else if (w_commit && r_rdwr_n) begin
         r_rd_csr    <= r_sel_csr;
         r_csr_rdata <= mko_csr_pack(r_int_pend, r_par_err, r_rt_adr);
      end
   end

   // Interrupt pending flag; an event in the same cycle as a clear wins.
   always_ff @(posedge i_clk_16) begin
      if (i_reset) begin
         r_int_pend <= 1'b0;
      end else if (i_evt) begin
         r_int_pend <= 1'b1;
      end else if (w_csr_clr) begin
         r_int_pend <= 1'b0;
      end
   end

`ifdef MKO_DEV_PARITY_EN
   // RT strap capture with parity check while the host holds device reset.
   always_ff @(posedge i_clk_16) begin
      if (i_reset) begin
         r_rt_adr  <= 5'd0;
         r_par_err <= 1'b0;
      end else if (!i_mko_res_n) begin
         r_rt_adr  <= i_mko_rdat;
         r_par_err <= mko_strap_par_err(i_mko_rdat, i_mko_rdatp);
      end
   end
`else
   logic w_unused_rdatp;
   assign w_unused_rdatp = i_mko_rdatp;

   // RT strap capture while the host holds device reset; parity not checked.
   always_ff @(posedge i_clk_16) begin
      if (i_reset) begin
         r_rt_adr  <= 5'd0;
         r_par_err <= 1'b0;
      end else if (!i_mko_res_n) begin
         r_rt_adr  <= i_mko_rdat;
         r_par_err <= 1'b0;
      end
   end
`endif

   mko_dev_mem #(
      .AW (MEM_AW)
   ) u_mem (
      .i_clk   (i_clk_16),
      .i_we    (w_mem_we),
      .i_re    (w_mem_re),
      .i_addr  (r_mem_adr),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rdata)
   );

   assign w_rdata        = r_rd_csr ? r_csr_rdata : w_mem_rdata;
   assign io_data_mko    = r_drive ? w_rdata : 16'hzzzz;
   assign o_mko_readyd_n = r_readyd_n;
   assign o_mko_int      = r_int_pend;

endmodule

// File: tb/tb_mko_dev_responder.sv
// -----------------------------------------------------------------------------
// tb_mko_dev_responder
// Scoreboard bench: each issued transfer pushes its expected response and
// acknowledge edge into a queue; a monitor pops and compares whenever
// READYD_N falls. Expected values come from a behavioural model (word array
// plus CSR status fields) updated with the transfer rules.
// -----------------------------------------------------------------------------
module tb_mko_dev_responder;

   localparam int W  = 2;
   localparam int AW = 6;

   typedef struct {
      bit          rd;
      logic [15:0] data;
      int          exp_cyc;
   } sb_t;

   logic        clk;
   logic        rst;
   logic        res_n;
   logic        strb_n;
   logic        sel_n;
   logic        rdwr_n;
   logic [15:0] adr;
   logic [4:0]  rdat;
   logic        rdatp;
   logic        evt;
   logic        readyd_n;
   logic        mko_int;
   logic        tb_drv_en;
   logic [15:0] tb_drv_val;
   wire  [15:0] bus;

   assign bus = tb_drv_en ? tb_drv_val : 16'hzzzz;

   int   cyc;
   int   total;
   int   bad;
   sb_t  sb_q[$];

   logic [15:0] m_mem [0:(1<<AW)-1];
   bit          m_int;
   bit          m_par;
   logic [4:0]  m_rt;

   mko_dev_responder #(
      .WAIT_CYCLES (W),
      .MEM_AW      (AW)
   ) dut (
      .i_clk_16       (clk),
      .i_reset        (rst),
      .i_mko_res_n    (res_n),
      .i_mko_strbd_n  (strb_n),
      .i_mko_select_n (sel_n),
      .i_mko_rdwr_n   (rdwr_n),
      .i_adr_mko      (adr),
      .io_data_mko    (bus),
      .i_mko_rdat     (rdat),
      .i_mko_rdatp    (rdatp),
      .o_mko_readyd_n (readyd_n),
      .o_mko_int      (mko_int),
      .i_evt          (evt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] model_read(input logic [15:0] a);
      if (a[12]) return {m_int, m_par, 9'b0, m_rt};
      return m_mem[a[AW-1:0]];
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_bus_free(input string name);
      tb_drv_en  = 1'b1;
      tb_drv_val = 16'h0F0F;
      #1;
      check(name, bus, 16'h0F0F);
      tb_drv_en  = 1'b0;
   endtask

   // Monitor: every falling READYD_N must match the oldest expected transfer.
   initial begin
      sb_t it;
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && readyd_n === 1'b0) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_ready: got READYD_N=0 expected 1 (cycle %0d)", cyc);
            end else begin
               it = sb_q.pop_front();
               check("ack_latency", 16'(cyc), 16'(it.exp_cyc));
               if (it.rd) check("read_data", bus, it.data);
            end
         end
         prev = readyd_n;
      end
   end

   // One host transfer. abort_a >= 0 lifts the strobe after abort_a+1 edges
   // in WAIT; evt_commit pulses EVT_I on the commit edge.
   task automatic txn(input bit rd, input logic [15:0] a, input logic [15:0] wd,
                      input int hold, input int abort_a, input bit evt_commit);
      int k;
      int guard;
      logic [15:0] exp;
      @(negedge clk);
      adr = a; rdwr_n = rd; tb_drv_en = !rd; tb_drv_val = wd;
      strb_n = 1'b0; sel_n = 1'b0;
      k = cyc;
      if (abort_a >= 0) begin
         repeat (abort_a + 1) @(negedge clk);
         strb_n = 1'b1; sel_n = 1'b1; tb_drv_en = 1'b0;
         repeat (W + 3) @(negedge clk);
         check("abort_ready", {15'd0, readyd_n}, 16'd1);
         return;
      end
      exp = rd ? model_read(a) : 16'h0000;
      sb_q.push_back('{rd, exp, k + W + 2});
      if (!rd) begin
         if (!a[12]) m_mem[a[AW-1:0]] = wd;
         else if (wd[15]) m_int = 1'b0;
      end
      if (evt_commit) m_int = 1'b1;
      if (evt_commit) begin
         repeat (W + 1) @(negedge clk);
         evt = 1'b1;
         @(negedge clk);
         evt = 1'b0;
      end
      guard = 0;
      while (readyd_n !== 1'b0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (readyd_n !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got READYD_N=%b expected 0", readyd_n);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         strb_n = 1'b1; sel_n = 1'b1; tb_drv_en = 1'b0;
         repeat (3) @(negedge clk);
         return;
      end
      repeat (hold) begin
         @(negedge clk);
         check("hold_ready", {15'd0, readyd_n}, 16'd0);
         if (rd) check("hold_data", bus, exp);
      end
      strb_n = 1'b1; sel_n = 1'b1; tb_drv_en = 1'b0;
      @(negedge clk);
      check("release_ready", {15'd0, readyd_n}, 16'd1);
      if (rd) check_bus_free("release_bus");
   endtask

   task automatic pulse_evt();
      @(negedge clk);
      evt = 1'b1;
      @(negedge clk);
      evt = 1'b0;
      m_int = 1'b1;
   endtask

   task automatic strap(input logic [4:0] d, input logic p);
      @(negedge clk);
      res_n = 1'b0; rdat = d; rdatp = p;
      repeat (2) @(negedge clk);
      check("resn_ready", {15'd0, readyd_n}, 16'd1);
      res_n = 1'b1;
      m_rt = d;
`ifdef MKO_DEV_PARITY_EN
      m_par = ((^d) != p);
`else
      m_par = 1'b0;
`endif
      rdat = $urandom_range(0, 31);
      rdatp = $urandom_range(0, 1);
   endtask

   initial begin
      logic [15:0] a;
      int guard;
      cyc = 0; total = 0; bad = 0;
      rst = 1'b1; res_n = 1'b1; strb_n = 1'b1; sel_n = 1'b1; rdwr_n = 1'b1;
      adr = 16'h0000; rdat = 5'd0; rdatp = 1'b0; evt = 1'b0;
      tb_drv_en = 1'b0; tb_drv_val = 16'h0000;
      m_int = 1'b0; m_par = 1'b0; m_rt = 5'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_ready", {15'd0, readyd_n}, 16'd1);
      check("reset_int", {15'd0, mko_int}, 16'd0);
      check_bus_free("reset_bus");
      txn(1'b1, 16'h1000, 16'h0000, 1, -1, 1'b0);

      for (int i = 0; i < (1 << AW); i++)
         txn(1'b0, 16'(i), 16'($urandom), 1, -1, 1'b0);

      // Write then read back, read latency checked by the monitor.
      txn(1'b0, 16'h0003, 16'hA5A5, 1, -1, 1'b0);
      txn(1'b1, 16'h0003, 16'h0000, 2, -1, 1'b0);

      // Aborted write leaves the old word.
      txn(1'b0, 16'h0005, 16'h1234, 1, 1, 1'b0);
      txn(1'b1, 16'h0005, 16'h0000, 1, -1, 1'b0);

      // Strap capture with and without a parity mismatch.
      strap(5'b10110, 1'b1);
      txn(1'b1, 16'h1000, 16'h0000, 1, -1, 1'b0);
      strap(5'b10110, 1'b0);
      txn(1'b1, 16'h1000, 16'h0000, 1, -1, 1'b0);

      // Interrupt set, clear, and set-wins-over-clear.
      pulse_evt();
      check("int_set", {15'd0, mko_int}, 16'd1);
      txn(1'b0, 16'h1000, 16'h8000, 1, -1, 1'b0);
      check("int_clear", {15'd0, mko_int}, 16'd0);
      pulse_evt();
      txn(1'b0, 16'h1000, 16'h8000, 1, -1, 1'b1);
      check("int_set_wins", {15'd0, mko_int}, 16'd1);

      // Long HOLD.
      txn(1'b1, 16'h0003, 16'h0000, 10, -1, 1'b0);

      // Reset during HOLD of a read.
      @(negedge clk);
      adr = 16'h0003; rdwr_n = 1'b1; strb_n = 1'b0; sel_n = 1'b0;
      sb_q.push_back('{1'b1, model_read(16'h0003), cyc + W + 2});
      guard = 0;
      while (readyd_n !== 1'b0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_hold_ready", {15'd0, readyd_n}, 16'd1);
      check_bus_free("rst_hold_bus");
      rst = 1'b0; strb_n = 1'b1; sel_n = 1'b1;
      m_int = 1'b0; m_par = 1'b0; m_rt = 5'd0;
      @(negedge clk);
      check("rst_int", {15'd0, mko_int}, 16'd0);
      txn(1'b1, 16'h0003, 16'h0000, 1, -1, 1'b0);
      txn(1'b1, 16'h1000, 16'h0000, 1, -1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) pulse_evt();
         a = 16'($urandom);
         a[12] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0)
            txn(1'($urandom), a, 16'($urandom), 1, $urandom_range(0, W - 1), 1'b0);
         else
            txn(1'($urandom), a, 16'($urandom), $urandom_range(1, 3), -1, 1'b0);
         check("rand_int", {15'd0, mko_int}, {15'd0, m_int});
      end

      repeat (4) @(negedge clk);
      check("sb_empty", 16'(sb_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
